// File: rtl/register_subtraction.sv
// Registered W-bit subtractor with status flags and a valid/ready output stage
// built from a main result register plus one skid entry (no combinational ready path).
module register_subtraction #(
    parameter int W = 30
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   mode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic [3:0]   flags
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t       state, state_nx;
    logic [W:0]   ext;
    logic [W-1:0] new_diff;
    logic [3:0]   new_flags;
    logic [W-1:0] skid_diff;
    logic [3:0]   skid_flags;
    logic         accept, drain;
    logic         load_main_new, load_main_skid, load_skid;

    // ext[W] is the unsigned borrow (a < b)
    always_comb begin
        ext       = {1'b0, a} - {1'b0, b};
        new_diff  = ext[W-1:0];
        new_flags = '0;
        new_flags[2] = (new_diff == '0);
        if (mode != 2'b00) begin
            new_flags[1] = (a[W-1] != b[W-1]) && (new_diff[W-1] != a[W-1]);
            new_flags[3] = new_diff[W-1];
        end else begin
            new_flags[0] = ext[W];
        end
    end

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= EMPTY;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        load_main_new  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_main_new = 1'b1;
                    state_nx      = ONE;
                end
            end
            ONE: begin
                if (drain && accept) begin
                    load_main_new = 1'b1;
                end else if (drain) begin
                    state_nx = EMPTY;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nx  = FULL;
                end
            end
            FULL: begin
                if (drain) begin
                    load_main_skid = 1'b1;
                    state_nx       = ONE;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            diff       <= '0;
            flags      <= '0;
            skid_diff  <= '0;
            skid_flags <= '0;
        end else begin
            if (load_main_new) begin
                diff  <= new_diff;
                flags <= new_flags;
            end else if (load_main_skid) begin
                diff  <= skid_diff;
                flags <= skid_flags;
            end
            if (load_skid) begin
                skid_diff  <= new_diff;
                skid_flags <= new_flags;
            end
        end
    end

endmodule
